// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath/memory side.
// Handshake: mem_req stays high (with iord/mem_we stable) until the cycle mem_ready=1; that cycle completes the access.
interface mips_multicycle_ctrl_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               alu_zero;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               iord;
  logic               ir_we;
  logic               pc_we;
  logic [1:0]         pc_src;
  logic               reg_dst;
  logic               reg_we;
  logic               mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               fault;
  logic [1:0]         fault_cause;
  logic [2:0]         state_o;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_dst, reg_we,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, fault, fault_cause, state_o
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_dst, reg_we,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, fault, fault_cause, state_o
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait timeout and sticky fault reporting.
// Optional jump support (opcode 000010) is enabled by defining MIPS_JUMP_EN.
module mips_multicycle_ctrl #(
  parameter int ALUOP_W      = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                  clk,
  input logic                  rst,
  mips_multicycle_ctrl_if.master bus
);
  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_FN   = 2'b10;
  localparam logic [1:0] CAUSE_MEMT = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_wait_cnt;
  logic [5:0]    r_opcode;
  logic [5:0]    r_funct;
  logic          r_fault;
  logic [1:0]    r_fault_cause;

  state_t             w_state_next;
  logic [CW-1:0]      w_wait_next;
  logic               w_set_fault;
  logic [1:0]         w_cause;
  logic               w_timeout;
  logic               w_mem_req;
  logic               w_mem_we;
  logic               w_iord;
  logic               w_ir_we;
  logic               w_pc_we;
  logic [1:0]         w_pc_src;
  logic               w_reg_dst;
  logic               w_reg_we;
  logic               w_mem_to_reg;
  logic               w_alu_src_a;
  logic [1:0]         w_alu_src_b;
  logic [ALUOP_W-1:0] w_alu_op;

  assign w_timeout = (MEM_WAIT_MAX != 0) && (r_wait_cnt == CW'(MEM_WAIT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= '0;
      r_opcode      <= '0;
      r_funct       <= '0;
      r_fault       <= 1'b0;
      r_fault_cause <= 2'b00;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (r_state == S_DECODE) begin
        r_opcode <= bus.opcode;
        r_funct  <= bus.funct;
      end
      if (w_set_fault) begin
        r_fault       <= 1'b1;
        r_fault_cause <= w_cause;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = '0;
    w_set_fault  = 1'b0;
    w_cause      = 2'b00;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = 2'b00;
    w_reg_dst    = 1'b0;
    w_reg_we     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = ALU_ADD;

    case (r_state)
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          w_ir_we      = 1'b1;
          w_pc_we      = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_set_fault  = 1'b1;
          w_cause      = CAUSE_MEMT;
          w_state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here so beq resolves in EXE.
        w_alu_src_b = 2'b11;
        case (bus.opcode)
          OPC_R: begin
            if (bus.funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
              w_state_next = S_EXE;
            end else begin
              w_set_fault  = 1'b1;
              w_cause      = CAUSE_FN;
              w_state_next = S_TRAP;
            end
          end
          OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ: w_state_next = S_EXE;
          OPC_J: begin
`ifdef MIPS_JUMP_EN
            w_pc_src     = 2'b10;
            w_pc_we      = 1'b1;
            w_state_next = S_FETCH;
`else
            w_set_fault  = 1'b1;
            w_cause      = CAUSE_OPC;
            w_state_next = S_TRAP;
`endif
          end
          default: begin
            w_set_fault  = 1'b1;
            w_cause      = CAUSE_OPC;
            w_state_next = S_TRAP;
          end
        endcase
      end
      S_EXE: begin
        w_alu_src_a = 1'b1;
        case (r_opcode)
          OPC_R: begin
            case (r_funct)
              FN_SUB:  w_alu_op = ALU_SUB;
              FN_AND:  w_alu_op = ALU_AND;
              FN_OR:   w_alu_op = ALU_OR;
              FN_SLT:  w_alu_op = ALU_SLT;
              default: w_alu_op = ALU_ADD;
            endcase
            w_state_next = S_WB;
          end
          OPC_ADDI: begin
            w_alu_src_b  = 2'b10;
            w_state_next = S_WB;
          end
          OPC_LW, OPC_SW: begin
            w_alu_src_b  = 2'b10;
            w_state_next = S_MEM;
          end
          OPC_BEQ: begin
            w_alu_op     = ALU_SUB;
            w_pc_src     = 2'b01;
            w_pc_we      = bus.alu_zero;
            w_state_next = S_FETCH;
          end
          default: w_state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = (r_opcode == OPC_SW);
        if (bus.mem_ready) begin
          w_state_next = (r_opcode == OPC_LW) ? S_WB : S_FETCH;
        end else if (w_timeout) begin
          w_set_fault  = 1'b1;
          w_cause      = CAUSE_MEMT;
          w_state_next = S_TRAP;
        end
      end
      S_WB: begin
        w_reg_we     = 1'b1;
        w_reg_dst    = (r_opcode == OPC_R);
        w_mem_to_reg = (r_opcode == OPC_LW);
        w_state_next = S_FETCH;
      end
      default: w_state_next = S_TRAP;
    endcase

    // Count only while an access is still pending in the same state; saturate so it never wraps.
    if (w_mem_req && !bus.mem_ready && (w_state_next == r_state) && (r_wait_cnt != '1)) begin
      w_wait_next = r_wait_cnt + 1'b1;
    end
  end

  assign bus.mem_req     = w_mem_req    & ~rst;
  assign bus.mem_we      = w_mem_we     & ~rst;
  assign bus.iord        = w_iord       & ~rst;
  assign bus.ir_we       = w_ir_we      & ~rst;
  assign bus.pc_we       = w_pc_we      & ~rst;
  assign bus.pc_src      = rst ? 2'b00 : w_pc_src;
  assign bus.reg_dst     = w_reg_dst    & ~rst;
  assign bus.reg_we      = w_reg_we     & ~rst;
  assign bus.mem_to_reg  = w_mem_to_reg & ~rst;
  assign bus.alu_src_a   = w_alu_src_a  & ~rst;
  assign bus.alu_src_b   = rst ? 2'b00 : w_alu_src_b;
  assign bus.alu_op      = rst ? '0 : w_alu_op;
  assign bus.fault       = r_fault;
  assign bus.fault_cause = r_fault_cause;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one default instance plus one with MEM_WAIT_MAX=3.
module tb_mips_multicycle_ctrl;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.ALUOP_W(AW)) bus ();
  mips_multicycle_ctrl_if #(.ALUOP_W(AW)) bus3 ();

  mips_multicycle_ctrl #(.ALUOP_W(AW), .MEM_WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mips_multicycle_ctrl #(.ALUOP_W(AW), .MEM_WAIT_MAX(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  function automatic logic [16:0] ctl(input logic req, we, io, irw, pcw, input logic [1:0] pcs,
                                      input logic rd, rw, m2r, sa, input logic [1:0] sb,
                                      input logic [3:0] op);
    return {req, we, io, irw, pcw, pcs, rd, rw, m2r, sa, sb, op};
  endfunction

  function automatic logic [16:0] obs_ctl();
    return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.pc_src, bus.reg_dst,
            bus.reg_we, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [2:0] st, input logic [16:0] c);
    #1;
    chk({tag, "_state"}, 32'(bus.state_o), 32'(st));
    chk({tag, "_ctl"}, 32'(obs_ctl()), 32'(c));
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // FETCH (ready) then DECODE, leaving the bench at the start of the cycle after DECODE.
  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    bus.mem_ready = 1'b1;
    bus.opcode    = op;
    bus.funct     = fn;
    chk_cyc({tag, "_fetch"}, 3'd0, ctl(1,0,0,1,1,2'b00,0,0,0,0,2'b01,4'd0));
    nxt();
    chk_cyc({tag, "_decode"}, 3'd1, ctl(0,0,0,0,0,2'b00,0,0,0,0,2'b11,4'd0));
    nxt();
  endtask

  task automatic run_r(input string tag, input logic [5:0] fn, input logic [3:0] op);
    fetch_decode(tag, 6'b000000, fn);
    bus.opcode = 6'b111111;
    chk_cyc({tag, "_exe"}, 3'd2, ctl(0,0,0,0,0,2'b00,0,0,0,1,2'b00,op));
    nxt();
    chk_cyc({tag, "_wb"}, 3'd4, ctl(0,0,0,0,0,2'b00,1,1,0,0,2'b00,4'd0));
    nxt();
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
    bus3.opcode = 6'd0; bus3.funct = 6'b100000; bus3.alu_zero = 1'b0; bus3.mem_ready = 1'b0;
    nxt();
    chk_cyc("reset", 3'd0, 17'd0);
    chk("reset_fault", 32'(bus.fault), 32'd0);
    chk("reset_cause", 32'(bus.fault_cause), 32'd0);
    rst = 1'b0;

    run_r("add", 6'b100000, 4'd0);
    run_r("sub", 6'b100010, 4'd1);
    run_r("and", 6'b100100, 4'd2);
    run_r("or",  6'b100101, 4'd3);
    run_r("slt", 6'b101010, 4'd4);

    fetch_decode("addi", 6'b001000, 6'd0);
    chk_cyc("addi_exe", 3'd2, ctl(0,0,0,0,0,2'b00,0,0,0,1,2'b10,4'd0));
    nxt();
    chk_cyc("addi_wb", 3'd4, ctl(0,0,0,0,0,2'b00,0,1,0,0,2'b00,4'd0));
    nxt();

    fetch_decode("lw", 6'b100011, 6'd0);
    bus.opcode = 6'b111111;
    chk_cyc("lw_exe", 3'd2, ctl(0,0,0,0,0,2'b00,0,0,0,1,2'b10,4'd0));
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk_cyc("lw_mem_wait", 3'd3, ctl(1,0,1,0,0,2'b00,0,0,0,0,2'b00,4'd0));
    end
    nxt();
    bus.mem_ready = 1'b1;
    chk_cyc("lw_mem_done", 3'd3, ctl(1,0,1,0,0,2'b00,0,0,0,0,2'b00,4'd0));
    nxt();
    chk_cyc("lw_wb", 3'd4, ctl(0,0,0,0,0,2'b00,0,1,1,0,2'b00,4'd0));
    nxt();

    fetch_decode("sw", 6'b101011, 6'd0);
    chk_cyc("sw_exe", 3'd2, ctl(0,0,0,0,0,2'b00,0,0,0,1,2'b10,4'd0));
    nxt();
    chk_cyc("sw_mem", 3'd3, ctl(1,1,1,0,0,2'b00,0,0,0,0,2'b00,4'd0));
    nxt();

    fetch_decode("beq_t", 6'b000100, 6'd0);
    bus.alu_zero = 1'b1;
    chk_cyc("beq_t_exe", 3'd2, ctl(0,0,0,0,1,2'b01,0,0,0,1,2'b00,4'd1));
    nxt();
    fetch_decode("beq_n", 6'b000100, 6'd0);
    bus.alu_zero = 1'b0;
    chk_cyc("beq_n_exe", 3'd2, ctl(0,0,0,0,0,2'b01,0,0,0,1,2'b00,4'd1));
    nxt();
    chk_cyc("beq_n_back", 3'd0, ctl(1,0,0,1,1,2'b00,0,0,0,0,2'b01,4'd0));

`ifdef MIPS_JUMP_EN
    bus.opcode = 6'b000010;
    nxt();
    chk_cyc("j_decode", 3'd1, ctl(0,0,0,0,1,2'b10,0,0,0,0,2'b11,4'd0));
    nxt();
    chk_cyc("j_back", 3'd0, ctl(1,0,0,1,1,2'b00,0,0,0,0,2'b01,4'd0));
`else
    fetch_decode("j", 6'b000010, 6'd0);
    chk_cyc("j_trap", 3'd5, 17'd0);
    chk("j_cause", 32'(bus.fault_cause), 32'd1);
    do_reset();
`endif

    // Reset while sw waits in MEM.
    fetch_decode("swr", 6'b101011, 6'd0);
    nxt();
    bus.mem_ready = 1'b0;
    chk_cyc("swr_mem", 3'd3, ctl(1,1,1,0,0,2'b00,0,0,0,0,2'b00,4'd0));
    rst = 1'b1;
    chk_cyc("swr_rst_now", 3'd0, 17'd0);
    nxt();
    chk_cyc("swr_rst_next", 3'd0, 17'd0);
    chk("swr_fault", 32'(bus.fault), 32'd0);
    rst = 1'b0;
    chk_cyc("swr_release", 3'd0, ctl(1,0,0,0,0,2'b00,0,0,0,0,2'b01,4'd0));

    fetch_decode("illop", 6'b111111, 6'd0);
    for (int i = 0; i < 3; i++) begin
      chk_cyc("illop_trap", 3'd5, 17'd0);
      chk("illop_fault", 32'(bus.fault), 32'd1);
      chk("illop_cause", 32'(bus.fault_cause), 32'd1);
      nxt();
    end
    do_reset();
    chk("illop_cleared", 32'(bus.fault), 32'd0);
    fetch_decode("illfn", 6'b000000, 6'b000111);
    for (int i = 0; i < 3; i++) begin
      chk_cyc("illfn_trap", 3'd5, 17'd0);
      chk("illfn_fault", 32'(bus.fault), 32'd1);
      chk("illfn_cause", 32'(bus.fault_cause), 32'd2);
      nxt();
    end

    // Timeout instance: four FETCH cycles without mem_ready.
    bus3.mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_fetch_state", 32'(bus3.state_o), 32'd0);
      chk("to_fetch_req", 32'(bus3.mem_req), 32'd1);
      nxt();
    end
    #1;
    chk("to_trap_state", 32'(bus3.state_o), 32'd5);
    chk("to_trap_fault", 32'(bus3.fault), 32'd1);
    chk("to_trap_cause", 32'(bus3.fault_cause), 32'd3);

    do_reset();
    for (int i = 0; i < 3; i++) nxt();
    bus3.mem_ready = 1'b1;
    #1;
    chk("lim_fetch_state", 32'(bus3.state_o), 32'd0);
    nxt();
    #1;
    chk("lim_decode_state", 32'(bus3.state_o), 32'd1);
    chk("lim_fault", 32'(bus3.fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised multicycle MIPS control FSM; the next generation of the basic fetch/decode/exe/mem controller.
- Sequences FETCH/DECODE/EXE/MEM/WB/TRAP and drives datapath enables, mux selects and ALU op.
- Adds memory-ready handshake with wait timeout, branch resolution, write-back state, and sticky fault reporting for illegal opcode/funct.
- Sits between instruction register/memory interface and the register file/ALU datapath.

Parameters:
- ALUOP_W, 4, width of alu_op (must be >= 3); codes zero-extended.
- MEM_WAIT_MAX, 15, max wait cycles on mem_ready before timeout fault; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write
- iord  out  1  address select: 0=PC, 1=ALUOut
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- pc_src  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
- reg_dst  out  1  1=rd, 0=rt
- reg_we  out  1  register file write
- mem_to_reg  out  1  1=memory data, 0=ALUOut
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  ALUOP_W  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT
- fault  out  1  sticky fault flag
- fault_cause  out  2  01=illegal opcode, 10=illegal funct, 11=mem timeout
- state_o  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, TRAP=5.
- Reset (async): state=FETCH, wait counter=0, latched opcode/funct=0, fault=0, fault_cause=00. All control outputs are forced to 0 while rst is high.
- Outputs not named for a state default to 0.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - ir_we=1 and pc_we=1 only in the cycle mem_ready=1; the FSM then moves to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE:
  - Latch opcode/funct into internal registers; EXE/MEM/WB use the latched copies.
  - alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target precompute).
  - Legal: R(000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010; addi 001000; lw 100011; sw 101011; beq 000100. Legal -> EXE.
  - R with any other funct -> TRAP, cause 10. Any other opcode -> TRAP, cause 01.
- EXE:
  - R: alu_src_a=1, alu_src_b=00, alu_op from funct -> WB.
  - addi/lw/sw: alu_src_a=1, alu_src_b=10, alu_op=ADD. addi -> WB; lw/sw -> MEM.
  - beq: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01, pc_we=alu_zero -> FETCH.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for sw. Holds until mem_ready.
  - On mem_ready: lw -> WB, sw -> FETCH.
- WB:
  - reg_we=1; reg_dst=1 for R, 0 for addi/lw; mem_to_reg=1 for lw only -> FETCH.
- TRAP:
  - All controls 0; fault=1 and fault_cause are held; exits only on rst.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or on leaving FETCH/MEM.
  - If MEM_WAIT_MAX!=0, counter==MEM_WAIT_MAX and mem_ready=0 -> TRAP, cause 11.
  - mem_ready in the same cycle as the limit wins; no fault is raised.
- Latency with zero wait (cycles per instruction): R/addi/sw=4, lw=5, beq=3, j=2.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-access drops mem_req immediately; no partial write-back.

Optional Feature:
- Macro MIPS_JUMP_EN.
- Defined: opcode 000010 (j) is legal. In DECODE: pc_src=10, pc_we=1, then FETCH.
- Undefined: opcode 000010 -> TRAP, cause 01.

Test Plan:
- rst pulse mid-MEM of sw, mem_ready=0 -> next cycle state_o=0, all outputs 0, fault=0; after release, FETCH with mem_req=1.
- add (opcode 0, funct 100000), mem_ready=1 always -> states 0,1,2,4,0; WB cycle reg_we=1, reg_dst=1, mem_to_reg=0; EXE alu_op=0, alu_src_b=00.
- lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_req=1, iord=1, mem_we=0; then WB with mem_to_reg=1, reg_dst=0.
- beq with alu_zero=1, then alu_zero=0 -> EXE pc_we=1, pc_src=01, alu_op=1; second instance pc_we=0; both return to FETCH after 3 cycles.
- opcode 111111, then R funct 000111 -> TRAP, fault=1, fault_cause=01; after reset, second case gives cause 10; state_o=5 held.
- MEM_WAIT_MAX=3, mem_ready stuck 0 in FETCH -> TRAP after 4th cycle, cause 11; repeat with mem_ready=1 exactly on limit cycle -> DECODE, no fault.
